// File: rtl/line_score_counter.sv
// line_score_counter
//   Keeps the two-digit decimal line-clear score shown on the score display.
//   The playfield row-clear detector sends line-clear events of 1..MAX_ROWS
//   rows. The block adds one row per clock in BCD and stops counting at 99.
//
//   Ports
//     i_clk          system clock; all logic runs on the rising edge
//     i_rst          synchronous, active-high reset
//     i_clear_valid  a line-clear event is present this cycle
//     i_clear_rows   rows cleared by the event; 0 is ignored, values above
//                    MAX_ROWS are clamped to MAX_ROWS
//     o_clear_ready  high when an event can be accepted (decoded from state)
//     i_game_reset   synchronous score clear at the start of a new game
//     o_row          registered packed score {tens, ones}; each field 0..9
//     o_busy         registered; high while an accepted event is being added
//     o_saturated    registered; sticky once an add was attempted at 99
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | waiting for an event; o_clear_ready=1
//   S_ADD  | adding one row per clock until the pending count runs out
module line_score_counter #(
   parameter int FIELD_W  = 5,
   parameter int MAX_ROWS = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_clear_valid,
   input  logic [2:0]           i_clear_rows,
   output logic                 o_clear_ready,
   input  logic                 i_game_reset,
   output logic [2*FIELD_W-1:0] o_row,
   output logic                 o_busy,
   output logic                 o_saturated
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_ADD  = 1'b1
   } state_t;

   localparam logic [2:0] MAX_ROWS_C = 3'(MAX_ROWS);

   state_t     r_state;
   logic [2:0] r_pending;
   logic [3:0] r_ones;
   logic [3:0] r_tens;
   logic       r_busy;
   logic       r_saturated;

   logic [2:0] w_rows_clamped;
   logic       w_clear;

   assign w_rows_clamped = (i_clear_rows > MAX_ROWS_C) ? MAX_ROWS_C : i_clear_rows;
   assign w_clear        = i_rst | i_game_reset;

   always_ff @(posedge i_clk) begin
      if (w_clear) begin
         // Any event offered in the same cycle is dropped, not queued.
         r_state     <= S_IDLE;
         r_pending   <= 3'd0;
         r_ones      <= 4'd0;
         r_tens      <= 4'd0;
         r_busy      <= 1'b0;
         r_saturated <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_clear_valid && (w_rows_clamped != 3'd0)) begin
                  r_pending <= w_rows_clamped;
                  r_state   <= S_ADD;
                  r_busy    <= 1'b1;
               end
            end
            S_ADD: begin
               if (r_ones != 4'd9) begin
                  r_ones <= r_ones + 4'd1;
               end else if (r_tens != 4'd9) begin
                  r_ones <= 4'd0;
                  r_tens <= r_tens + 4'd1;
               end else begin
                  // At 99 the remaining rows still take one cycle each, so
                  // event timing does not depend on the score value.
                  r_saturated <= 1'b1;
               end
               r_pending <= r_pending - 3'd1;
               // The <= also recovers from an unreachable zero pending count.
               if (r_pending <= 3'd1) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_clear_ready = (r_state == S_IDLE);
   assign o_busy        = r_busy;
   assign o_saturated   = r_saturated;
   assign o_row         = {{(FIELD_W-4){1'b0}}, r_tens, {(FIELD_W-4){1'b0}}, r_ones};

endmodule

// File: tb/tb_line_score_counter.sv
module tb_line_score_counter;

   logic       clk;
   logic       i_rst;
   logic       i_clear_valid;
   logic [2:0] i_clear_rows;
   logic       o_clear_ready;
   logic       i_game_reset;
   logic [9:0] o_row;
   logic       o_busy;
   logic       o_saturated;

   line_score_counter #(.FIELD_W(5), .MAX_ROWS(4)) dut (
      .i_clk         (clk),
      .i_rst         (i_rst),
      .i_clear_valid (i_clear_valid),
      .i_clear_rows  (i_clear_rows),
      .o_clear_ready (o_clear_ready),
      .i_game_reset  (i_game_reset),
      .o_row         (o_row),
      .o_busy        (o_busy),
      .o_saturated   (o_saturated)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [9:0] row;
      logic       busy;
      logic       sat;
      logic       ready;
      string      tag;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   // Reference model: score as a plain integer, rows still owed as a count.
   int   m_score = 0;
   int   m_pend  = 0;
   bit   m_sat   = 0;

   task automatic chk(input string name, input string tag, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s [%s] actual=%0d required=%0d at %0t", name, tag, act, exp, $time);
      end
   endtask

   // Monitor: the DUT presents a fresh registered output after every edge.
   always @(posedge clk) begin
      exp_t e;
      #2;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("row",       e.tag, int'(o_row),         int'(e.row));
         chk("busy",      e.tag, int'(o_busy),        int'(e.busy));
         chk("saturated", e.tag, int'(o_saturated),   int'(e.sat));
         chk("ready",     e.tag, int'(o_clear_ready), int'(e.ready));
      end
   end

   // Apply one cycle of inputs, advance the model across the coming edge,
   // queue the expected post-edge outputs, then move to the next cycle.
   task automatic drive(input logic r, input logic g, input logic v,
                        input logic [2:0] rows, input string tag);
      exp_t e;
      i_rst         = r;
      i_game_reset  = g;
      i_clear_valid = v;
      i_clear_rows  = rows;
      if (r || g) begin
         m_score = 0;
         m_pend  = 0;
         m_sat   = 0;
      end else if (m_pend > 0) begin
         if (m_score == 99) m_sat = 1;
         else               m_score = m_score + 1;
         m_pend = m_pend - 1;
      end else if (v && rows != 0) begin
         m_pend = (rows > 4) ? 4 : int'(rows);
      end
      e.row   = {5'(m_score / 10), 5'(m_score % 10)};
      e.busy  = (m_pend > 0);
      e.sat   = m_sat;
      e.ready = (m_pend == 0);
      e.tag   = tag;
      q.push_back(e);
      @(negedge clk);
      #1;
   endtask

   // One event, then idle until the model has consumed it.
   task automatic feed(input logic [2:0] rows, input string tag);
      drive(0, 0, 1, rows, tag);
      for (int k = 0; k < 8 && m_pend > 0; k++) drive(0, 0, 0, 3'd0, tag);
   endtask

   initial begin
      i_rst = 1'b1; i_game_reset = 1'b0; i_clear_valid = 1'b0; i_clear_rows = 3'd0;
      @(negedge clk); #1;

      drive(1, 0, 0, 3'd0, "reset");
      drive(0, 0, 0, 3'd0, "idle");

      // 08 + 4 -> 09,10,11,12
      feed(3'd4, "pre8a");
      feed(3'd4, "pre8b");
      feed(3'd4, "from08");

      // clear_rows 0 ignored, 6 clamps to 4
      drive(0, 0, 1, 3'd0, "rows0");
      drive(0, 0, 0, 3'd0, "rows0b");
      feed(3'd6, "rows6");
      feed(3'd7, "rows7");

      // 97 + 4 -> 98,99,99(sat),99
      drive(0, 1, 0, 3'd0, "greset");
      for (int i = 0; i < 24; i++) feed(3'd4, "to96");
      feed(3'd1, "to97");
      feed(3'd4, "sat");
      drive(0, 0, 1, 3'd2, "satmore");
      drive(0, 0, 0, 3'd0, "satmore");
      drive(0, 0, 0, 3'd0, "satmore");

      // game_reset on 2nd ADD cycle with valid high
      drive(0, 0, 1, 3'd4, "gr_mid");
      drive(0, 0, 0, 3'd0, "gr_mid");
      drive(0, 1, 1, 3'd3, "gr_mid");
      drive(0, 0, 0, 3'd0, "gr_after");
      drive(0, 0, 0, 3'd0, "gr_after");

      // valid held for 6 cycles with rows=1 -> +3
      for (int i = 0; i < 6; i++) drive(0, 0, 1, 3'd1, "held");
      drive(0, 0, 0, 3'd0, "held_end");

      // rst mid-ADD
      drive(0, 0, 1, 3'd3, "rst_mid");
      drive(1, 0, 1, 3'd3, "rst_mid");
      drive(0, 0, 0, 3'd0, "rst_after");

      // random traffic
      for (int i = 0; i < 600; i++) begin
         logic r, g, v;
         logic [2:0] rows;
         r    = ($urandom_range(0, 199) == 0);
         g    = ($urandom_range(0, 149) == 0);
         v    = ($urandom_range(0, 99) < 60);
         rows = 3'($urandom_range(0, 7));
         drive(r, g, v, rows, "rand");
      end
      drive(0, 0, 0, 3'd0, "tail");

      for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge clk);
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain actual=%0d required=0 entries left", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
